// File: rtl/quick_spi_slave.sv
// SPI slave with clk-domain oversampling of sclk/ss_n/mosi, configurable
// CPOL/CPHA, bit and byte ordering, and back-to-back words within one frame.
module quick_spi_slave #(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int BITS_ORDER  = 1,
  parameter int BYTES_ORDER = 1,
  parameter int WORD_BYTES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sclk,
  input  logic                    ss_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  output logic [8*WORD_BYTES-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    busy,
  output logic                    frame_abort
);

  localparam int N  = 8 * WORD_BYTES;
  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ACTIVE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DESEL = 2'd2;

  localparam logic CPOL_L = (CPOL != 0);

  logic [1:0]    r_sclk_s;
  logic [1:0]    r_ss_s;
  logic [1:0]    r_mosi_s;
  logic          r_sclk_d;
  logic          r_ss_d;
  logic [1:0]    r_state;
  logic [1:0]    r_settle;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_tx;
  logic [N-1:0]  r_rx;

  logic          w_sclk;
  logic          w_ss;
  logic          w_mosi;
  logic          w_rise;
  logic          w_fall;
  logic          w_lead;
  logic          w_trail;
  logic          w_sample;
  logic          w_shift;
  logic          w_ss_rise;
  logic          w_ss_fall;
  logic          w_last;
  logic [CW-1:0] w_cnt_next;
  logic [N-1:0]  w_rx_next;

  // Maps transmission position k to the bit index within the tx/rx word.
  function automatic logic [IW-1:0] f_idx(input logic [CW-1:0] k);
    int unsigned kbyte;
    int unsigned kbit;
    int unsigned byte_pos;
    int unsigned bit_pos;
    kbyte    = 32'(k) >> 3;
    kbit     = 32'(k) & 32'd7;
    byte_pos = (BYTES_ORDER != 0) ? (WORD_BYTES - 1 - kbyte) : kbyte;
    bit_pos  = (BITS_ORDER != 0) ? (7 - kbit) : kbit;
    return IW'(byte_pos * 8 + bit_pos);
  endfunction

  assign w_sclk    = r_sclk_s[1];
  assign w_ss      = r_ss_s[1];
  assign w_mosi    = r_mosi_s[1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_lead    = CPOL_L ? w_fall : w_rise;
  assign w_trail   = CPOL_L ? w_rise : w_fall;
  assign w_sample  = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift   = (CPHA != 0) ? w_lead : w_trail;
  assign w_ss_rise = w_ss & ~r_ss_d;
  assign w_ss_fall = ~w_ss & r_ss_d;
  assign w_last    = (r_cnt == CW'(N - 1));

  always_comb begin
    w_cnt_next = r_cnt;
    w_rx_next  = r_rx;
    if (w_sample) begin
      w_rx_next[f_idx(r_cnt)] = w_mosi;
      w_cnt_next = w_last ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_s    <= {CPOL_L, CPOL_L};
      r_ss_s      <= 2'b11;
      r_mosi_s    <= 2'b00;
      r_sclk_d    <= CPOL_L;
      r_ss_d      <= 1'b1;
      r_state     <= ST_WAIT_DESEL;
      r_settle    <= '0;
      r_cnt       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      r_sclk_s    <= {r_sclk_s[0], sclk};
      r_ss_s      <= {r_ss_s[0], ss_n};
      r_mosi_s    <= {r_mosi_s[0], mosi};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      case (r_state)
        // Synchronizer reset values read as "deselected"; wait until the
        // chain holds real samples before trusting ss_n high.
        ST_WAIT_DESEL: begin
          if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
          else if (w_ss)        r_state  <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state <= ST_ACTIVE;
            r_tx    <= tx_data;
            r_cnt   <= '0;
            busy    <= 1'b1;
            miso_oe <= 1'b1;
            if (CPHA == 0) miso <= tx_data[f_idx('0)];
            else           miso <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (w_sample) begin
            r_rx  <= w_rx_next;
            r_cnt <= w_cnt_next;
            if (w_last) begin
              rx_data  <= w_rx_next;
              rx_valid <= 1'b1;
              r_tx     <= tx_data;
            end
          end
          if (w_shift) miso <= r_tx[f_idx(r_cnt)];
          // A word finishing in the same cycle leaves w_cnt_next at zero.
          if (w_ss_rise) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
            miso        <= 1'b0;
            frame_abort <= (w_cnt_next != '0);
          end
        end
        default: r_state <= ST_WAIT_DESEL;
      endcase
    end
  end

endmodule
